// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM slave-port arbiter: FSM encodings, grant index width
// and the latched request record.
package sram_arbiter_pkg;

  localparam int GW = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } sreq_t;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin picker with optional fixed priority for index 0.
// Reusable by any arbiter that keeps a last-grant pointer.
module rr_pick
  import sram_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_ptr,
  input  logic          i_prio0,
  output logic [GW-1:0] o_grant,
  output logic          o_valid
);

  logic [GW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = |i_req;
    w_idx   = '0;
    // Scan far-to-near so the nearest requester after the pointer is written last.
    for (int k = N; k >= 1; k--) begin
      w_idx = GW'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) o_grant = w_idx;
    end
    if (i_prio0 && i_req[0]) o_grant = '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller slave port among NUM_MASTERS requesters, one access at a time,
// sequenced against the controller's stb/nak handshake.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter bit PRIO_M0     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    m_stb,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*4-1:0]  m_we,
  input  logic [NUM_MASTERS*32-1:0] m_din,
  output logic [31:0]               m_dout,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic                      s_stb,
  output logic [31:0]               s_addr,
  output logic [3:0]                s_we,
  output logic [31:0]               s_din,
  input  logic [47:0]               s_dout,
  input  logic                      s_nak
);

  logic [1:0]             r_state;
  logic [GW-1:0]          r_grant;
  logic [GW-1:0]          r_ptr;
  sreq_t                  r_req;
  logic                   r_stb;
  logic [31:0]            r_dout;
  logic [NUM_MASTERS-1:0] r_ack;

  logic [NUM_MASTERS-1:0] w_elig;
  logic [GW-1:0]          w_gnt;
  logic                   w_vld;
  logic                   w_unused;

  // The master acked this cycle still shows its old stb; keep it out of arbitration.
  assign w_elig   = m_stb & ~r_ack;
  assign w_unused = ^s_dout[47:32];

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .i_prio0 (PRIO_M0),
    .o_grant (w_gnt),
    .o_valid (w_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_req   <= '0;
      r_stb   <= 1'b0;
      r_dout  <= '0;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_grant <= w_gnt;
            r_req   <= '{addr: m_addr[w_gnt*32 +: 32],
                         we:   m_we[w_gnt*4 +: 4],
                         din:  m_din[w_gnt*32 +: 32]};
            r_stb   <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (s_nak) begin
            r_stb   <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!s_nak) begin
            if (r_req.we == 4'b0000) r_dout <= s_dout[31:0];
            r_ack[r_grant] <= 1'b1;
            r_ptr          <= r_grant;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_stb  = r_stb;
  assign s_addr = r_req.addr;
  assign s_we   = r_req.we;
  assign s_din  = r_req.din;
  assign m_dout = r_dout;
  assign m_ack  = r_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: two DUTs (PRIO_M0=0 and 1) share master stimulus,
// each driving its own cycle-accurate model of the SRAM controller handshake.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_stb;
  logic [95:0] m_addr;
  logic [11:0] m_we;
  logic [95:0] m_din;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_ctl
    logic [31:0] m_dout;
    logic [2:0]  m_ack;
    logic        s_stb;
    logic [31:0] s_addr;
    logic [3:0]  s_we;
    logic [31:0] s_din;
    logic [47:0] s_dout;
    logic        s_nak;
    logic [1:0]  st;
    logic [31:0] mem [16];
    logic [31:0] la, ld;
    logic [3:0]  lw;

    sram_arbiter #(.NUM_MASTERS(3), .PRIO_M0(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .m_stb(m_stb), .m_addr(m_addr), .m_we(m_we), .m_din(m_din),
      .m_dout(m_dout), .m_ack(m_ack), .s_stb(s_stb), .s_addr(s_addr), .s_we(s_we),
      .s_din(s_din), .s_dout(s_dout), .s_nak(s_nak)
    );

    // Controller model: accept stb, nak high two cycles, data/result in the third.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= 2'd0;
        s_nak  <= 1'b0;
        s_dout <= '0;
        la <= '0; ld <= '0; lw <= '0;
        for (int i = 0; i < 16; i++)
          mem[i] <= (i == 4) ? 32'hDEADBEEF : (i == 8) ? 32'hA5A5A5A5 : 32'h0;
      end else begin
        case (st)
          2'd0: if (s_stb) begin
            st <= 2'd1; s_nak <= 1'b1; la <= s_addr; lw <= s_we; ld <= s_din;
          end
          2'd1: st <= 2'd2;
          2'd2: begin
            st <= 2'd3; s_nak <= 1'b0;
            if (lw == 4'b0000) s_dout <= {16'hFFFF, mem[la[5:2]]};
            for (int b = 0; b < 4; b++)
              if (lw[b]) mem[la[5:2]][8*b +: 8] <= ld[8*b +: 8];
          end
          default: st <= 2'd0;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    m_addr[32*m +: 32] = a;
    m_we[4*m +: 4]     = w;
    m_din[32*m +: 32]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_stb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int idx_of(input logic [2:0] oh);
    int r = -1;
    for (int i = 0; i < 3; i++) if (oh[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    int ai[8];
    int ac[8];

    tbl[0] = '{0, 32'h0000_0010, 4'b0000, 32'h0,          32'hDEADBEEF};
    tbl[1] = '{1, 32'h0000_0020, 4'b0011, 32'h12345678,   32'hDEADBEEF};
    tbl[2] = '{2, 32'h0000_0020, 4'b0000, 32'h0,          32'hA5A55678};
    tbl[3] = '{0, 32'h0000_0024, 4'b1100, 32'hCAFEF00D,   32'hA5A55678};
    tbl[4] = '{1, 32'h0000_0024, 4'b0000, 32'h0,          32'hCAFE0000};
    tbl[5] = '{2, 32'h0000_003C, 4'b1111, 32'h01020304,   32'hCAFE0000};
    tbl[6] = '{0, 32'h0000_003C, 4'b0000, 32'h0,          32'h01020304};

    m_stb = '0; m_addr = '0; m_we = '0; m_din = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s_stb",  32'(g_ctl[0].s_stb),  32'h0);
    chk("rst_s_addr", g_ctl[0].s_addr,      32'h0);
    chk("rst_s_we",   32'(g_ctl[0].s_we),   32'h0);
    chk("rst_s_din",  g_ctl[0].s_din,       32'h0);
    chk("rst_m_dout", g_ctl[0].m_dout,      32'h0);
    chk("rst_m_ack",  32'(g_ctl[0].m_ack),  32'h0);
    chk("rst_m_ack_p", 32'(g_ctl[1].m_ack), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single accesses: grant muxing, latency and read/write data path.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) set_m(k, 32'hBAD0_0000 + k, 4'hF, 32'h5555_0000 + k);
      set_m(tbl[i].m, tbl[i].addr, tbl[i].we, tbl[i].din);
      m_stb[tbl[i].m] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); @(negedge clk);
        if (c == 1) begin
          chk($sformatf("v%0d_s_stb1", i), 32'(g_ctl[0].s_stb), 32'h1);
          chk($sformatf("v%0d_s_addr", i), g_ctl[0].s_addr, tbl[i].addr);
          chk($sformatf("v%0d_s_we", i), 32'(g_ctl[0].s_we), 32'(tbl[i].we));
          chk($sformatf("v%0d_s_din", i), g_ctl[0].s_din, tbl[i].din);
        end
        if (c == 2) chk($sformatf("v%0d_s_stb2", i), 32'(g_ctl[0].s_stb), 32'h1);
        if (c == 3) chk($sformatf("v%0d_s_stb3", i), 32'(g_ctl[0].s_stb), 32'h0);
        if (c < 5)  chk($sformatf("v%0d_ack_early", i), 32'(g_ctl[0].m_ack), 32'h0);
      end
      chk($sformatf("v%0d_ack", i), 32'(g_ctl[0].m_ack), 32'(1) << tbl[i].m);
      chk($sformatf("v%0d_dout", i), g_ctl[0].m_dout, tbl[i].exp_dout);
      m_stb = '0;
    end

    // Round-robin with all three requesting continuously.
    do_reset();
    set_m(0, 32'h10, 4'h0, 32'h0);
    set_m(1, 32'h20, 4'h0, 32'h0);
    set_m(2, 32'h24, 4'h0, 32'h0);
    @(posedge clk); #1 m_stb = 3'b001;
    @(posedge clk); #1 m_stb = 3'b111;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (g_ctl[0].m_ack != 3'b000) begin
        chk("rr_onehot", 32'($countones(g_ctl[0].m_ack)), 32'h1);
        ai[n] = idx_of(g_ctl[0].m_ack);
        ac[n] = cyc;
        n++;
      end
    end
    chk("rr_count", 32'(n), 32'd6);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr_order%0d", i), 32'(ai[i]), 32'(i % 3));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(ac[i] - ac[i-1]), 32'd5);
    end
    m_stb = '0;

    // Fixed priority: M0 and M2 together from pointer 0.
    do_reset();
    @(posedge clk); #1 m_stb = 3'b101;
    @(posedge clk); @(negedge clk);
    chk("prio_first", g_ctl[1].s_addr, 32'h10);
    chk("rr_first",   g_ctl[0].s_addr, 32'h24);
    n = 0;
    for (int c = 0; c < 15 && n < 2; c++) begin
      @(negedge clk);
      if (g_ctl[1].m_ack != 3'b000) begin
        ai[n] = int'(g_ctl[1].m_ack);
        ac[n] = cyc;
        n++;
      end
    end
    chk("prio_count", 32'(n), 32'd2);
    if (n == 2) begin
      chk("prio_ack0", 32'(ai[0]), 32'h1);
      chk("prio_ack1", 32'(ai[1]), 32'h4);
      chk("prio_gap", 32'(ac[1] - ac[0]), 32'd5);
    end
    m_stb = '0;

    // Reset during WAIT: access aborted, held request completes once after release.
    do_reset();
    set_m(1, 32'h10, 4'h0, 32'h0);
    @(posedge clk); #1 m_stb = 3'b010;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_s_stb", 32'(g_ctl[0].s_stb), 32'h0);
    chk("rstw_m_ack", 32'(g_ctl[0].m_ack), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("rstw_hold_ack", 32'(g_ctl[0].m_ack), 32'h0);
    end
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (g_ctl[0].m_ack != 3'b000) begin
        n++;
        chk("rstw_ack", 32'(g_ctl[0].m_ack), 32'h2);
        chk("rstw_dout", g_ctl[0].m_dout, 32'hDEADBEEF);
        m_stb = '0;
      end
    end
    chk("rstw_ack_count", 32'(n), 32'd1);

    // M1 holds stb one cycle past its ack: no regrant in the ack cycle, then a fresh access.
    do_reset();
    set_m(1, 32'h20, 4'h0, 32'h0);
    @(posedge clk); #1 m_stb = 3'b010;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("hold_ack_c%0d", c), 32'(g_ctl[0].m_ack),
          (c == 5 || c == 11) ? 32'h2 : 32'h0);
      if (c == 6) chk("hold_no_grant", 32'(g_ctl[0].s_stb), 32'h0);
      if (c == 7) begin
        chk("hold_regrant", 32'(g_ctl[0].s_stb), 32'h1);
        m_stb = '0;
      end
      if (c == 11) chk("hold_dout", g_ctl[0].m_dout, 32'hA5A5A5A5);
      if (c > 12) chk("hold_idle_stb", 32'(g_ctl[0].s_stb), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
